// File: rtl/pn_seq_detector.sv
// pn_seq_detector: 4-bit maximal-length LFSR (x^4+x^3+1) PN source plus an
// overlapping Moore-style 4-bit pattern detector with a saturating match counter.
// Optional external detector input is enabled by defining PN_SEQ_EXT_IN_EN,
// which adds the bit_in and use_ext ports.
module pn_seq_detector #(
  parameter logic [3:0]  SEED      = 4'b0001,
  parameter logic [3:0]  PATTERN   = 4'b1011,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
`ifdef PN_SEQ_EXT_IN_EN
  input  logic                 bit_in,
  input  logic                 use_ext,
`endif
  output logic                 pn_out,
  output logic                 z,
  output logic [CNT_WIDTH-1:0] match_count
);

  // All-zero is the LFSR lock-up state, so it is never used as a load value.
  localparam logic [3:0] SeedLegal = (SEED == 4'b0000) ? 4'b0001 : SEED;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo, StFull} fill_e;

  fill_e                fill_q, fill_d;
  logic [3:0]           lfsr_q, lfsr_d;
  logic [2:0]           hist_q, hist_d;
  logic                 z_q, z_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 d_bit;
  logic                 match;

  assign pn_out      = lfsr_q[3];
  assign z           = z_q;
  assign match_count = cnt_q;

  // Select the bit the detector samples this edge (pre-shift PN bit by default).
`ifdef PN_SEQ_EXT_IN_EN
  assign d_bit = use_ext ? bit_in : lfsr_q[3];
`else
  assign d_bit = lfsr_q[3];
`endif

  // Fill state register: tracks how many history bits are valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= StEmpty;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Fill next-state: advance on enabled edges until full, then hold.
  always_comb begin
    fill_d = fill_q;
    if (en) begin
      unique case (fill_q)
        StEmpty: fill_d = StOne;
        StOne:   fill_d = StTwo;
        StTwo:   fill_d = StFull;
        StFull:  fill_d = StFull;
        default: fill_d = StEmpty;
      endcase
    end
  end

  // Match decode: only once three history bits plus the current bit are valid.
  always_comb begin
    match = 1'b0;
    if (en && (fill_q == StFull) && ({hist_q, d_bit} == PATTERN)) begin
      match = 1'b1;
    end
  end

  // Datapath next-state: LFSR shift, history shift, match pulse, saturating count.
  always_comb begin
    lfsr_d = lfsr_q;
    hist_d = hist_q;
    cnt_d  = cnt_q;
    z_d    = match;
    if (en) begin
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      hist_d = {hist_q[1:0], d_bit};
    end
    if (match && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Datapath registers; reset takes priority over en.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SeedLegal;
      hist_q <= 3'b000;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      hist_q <= hist_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pn_seq_detector.sv
// Scoreboard bench for pn_seq_detector: a stimulus process pushes the expected
// outputs for each edge, a monitor pops and compares them after the edge.
module tb_pn_seq_detector;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          pn_out;
  logic          z;
  logic [CW-1:0] match_count;
`ifdef PN_SEQ_EXT_IN_EN
  logic          bit_in = 1'b0;
  logic          use_ext = 1'b0;
`endif

  always #5 clk = ~clk;

  pn_seq_detector #(
    .SEED      (4'b0001),
    .PATTERN   (4'b1011),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
`ifdef PN_SEQ_EXT_IN_EN
    .bit_in      (bit_in),
    .use_ext     (use_ext),
`endif
    .pn_out      (pn_out),
    .z           (z),
    .match_count (match_count)
  );

  typedef struct packed {
    logic          pn;
    logic          z;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: the documented PN stream from seed 0001, and a window of
  // the last four received bits.
  bit   stream[15] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
  int   m_pos = 0;
  bit   m_win[$];
  int   m_cnt = 0;
  bit   m_z = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; model advanced and expectation queued.
  task automatic step(input bit r, input bit e, input bit bi, input bit ue);
    bit   d;
    bit   ext;
    logic [3:0] w;
    exp_t ex;
    @(negedge clk);
    reset = r;
    en    = e;
`ifdef PN_SEQ_EXT_IN_EN
    bit_in  = bi;
    use_ext = ue;
    ext     = ue;
`else
    ext     = 1'b0;
`endif
    if (r) begin
      m_pos = 0;
      m_win.delete();
      m_cnt = 0;
      m_z   = 0;
    end else if (e) begin
      d = ext ? bi : stream[m_pos];
      m_win.push_back(d);
      if (m_win.size() > 4) void'(m_win.pop_front());
      m_z = 0;
      if (m_win.size() == 4) begin
        w = {m_win[0], m_win[1], m_win[2], m_win[3]};
        m_z = (w == 4'b1011);
      end
      if (m_z && m_cnt < 255) m_cnt++;
      m_pos = (m_pos + 1) % 15;
    end else begin
      m_z = 0;
    end
    ex.pn  = stream[m_pos];
    ex.z   = m_z;
    ex.cnt = CW'(m_cnt);
    sb_q.push_back(ex);
  endtask

  // Monitor: compare every edge that has a queued expectation.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        chk("pn_out", 32'(pn_out), 32'(ex.pn));
        chk("z", 32'(z), 32'(ex.z));
        chk("match_count", 32'(match_count), 32'(ex.cnt));
      end
    end
  end

  // Directed check sampled just after the edge applying the last step.
  task automatic direct_cnt(input string name, input int exp);
    @(posedge clk);
    #2;
    chk(name, 32'(match_count), 32'(exp));
  endtask

  initial begin
    int   guard;
    logic ob;
    bit   ov[7];
    ov = '{1, 0, 1, 1, 0, 1, 1};
    // Reset for two cycles with en=1 (reset has priority), then free run.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 45; i++) step(0, 1, 0, 0);
    direct_cnt("count_after_45", 3);
    // Hold for five cycles mid-stream, then resume.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    // Single-cycle reset mid-run, then refill.
    step(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    // Random enable with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 0, 0);
    end
    // Saturation from the PN stream alone: >300 matches.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4600; i++) step(0, 1, 0, 0);
    direct_cnt("count_saturated", 255);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
`ifdef PN_SEQ_EXT_IN_EN
    // Overlapping detection on the external input.
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, ov[i], 1);
    direct_cnt("ext_overlap_count", 2);
    // Random external traffic mixed with PN selection.
    for (int i = 0; i < 800; i++) begin
      ob = 1'($urandom_range(0, 1));
      step($urandom_range(0, 100) == 0, $urandom_range(0, 4) != 0, ob,
           $urandom_range(0, 3) != 0);
    end
    // Saturation through the external input.
    step(1, 0, 0, 0);
    for (int i = 0; i < 1200; i++) step(0, 1, ov[i % 3 == 0 ? 0 : (i % 3 == 1 ? 2 : 3)], 1);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 1, 1);
      step(0, 1, 0, 1);
      step(0, 1, 1, 1);
      step(0, 1, 1, 1);
    end
    direct_cnt("ext_count_saturated", 255);
`endif
    step(0, 0, 0, 0);
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
